// File: rtl/jtag_pkg.sv
// Shared JTAG TAP types and opcode helpers.
package jtag_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_ctrl_fsm_t;

    localparam int unsigned IDCODE_WIDTH = 32;

    // BYPASS is the all-ones instruction for a given IR length
    function automatic int unsigned bypass_op(input int unsigned ir_width);
        return (32'd1 << ir_width) - 32'd1;
    endfunction

    function automatic int unsigned user_op(input int unsigned base, input int unsigned idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm_ah.sv
// IEEE 1149.1 16-state TAP controller with asynchronous active-high reset.
module jtag_tap_fsm_ah
    import jtag_pkg::*;
(
    input  logic          tck,
    input  logic          trst,
    input  logic          tms,
    output tap_ctrl_fsm_t tap_state
);

    tap_ctrl_fsm_t state_q;
    tap_ctrl_fsm_t state_d;

    always_ff @(posedge tck or posedge trst) begin
        if (trst) state_q <= TEST_LOGIC_RESET;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_d = tms ? SELECT_DR  : RUN_TEST_IDLE;
            SELECT_DR:        state_d = tms ? SELECT_IR  : CAPTURE_DR;
            CAPTURE_DR:       state_d = tms ? EXIT1_DR   : SHIFT_DR;
            SHIFT_DR:         state_d = tms ? EXIT1_DR   : SHIFT_DR;
            EXIT1_DR:         state_d = tms ? UPDATE_DR  : PAUSE_DR;
            PAUSE_DR:         state_d = tms ? EXIT2_DR   : PAUSE_DR;
            EXIT2_DR:         state_d = tms ? UPDATE_DR  : SHIFT_DR;
            UPDATE_DR:        state_d = tms ? SELECT_DR  : RUN_TEST_IDLE;
            SELECT_IR:        state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = tms ? EXIT1_IR   : SHIFT_IR;
            SHIFT_IR:         state_d = tms ? EXIT1_IR   : SHIFT_IR;
            EXIT1_IR:         state_d = tms ? UPDATE_IR  : PAUSE_IR;
            PAUSE_IR:         state_d = tms ? EXIT2_IR   : PAUSE_IR;
            EXIT2_IR:         state_d = tms ? UPDATE_IR  : SHIFT_IR;
            UPDATE_IR:        state_d = tms ? SELECT_DR  : RUN_TEST_IDLE;
            default:          state_d = TEST_LOGIC_RESET;
        endcase
    end

    assign tap_state = state_q;

endmodule

// File: rtl/jtag_tap_multi_dr.sv
// JTAG TAP with IR, IDCODE, BYPASS and NUM_USER_DR parallel-capture/update user data registers.
module jtag_tap_multi_dr
    import jtag_pkg::*;
#(
    parameter int unsigned IR_WIDTH    = 4,
    parameter logic [31:0] IDCODE_VAL  = 32'h10F,
    parameter int unsigned IDCODE_OP   = 'h1,
    parameter int unsigned USER_BASE   = 'h4,
    parameter int unsigned NUM_USER_DR = 3,
    parameter int unsigned DR_WIDTH    = 32
) (
    input  logic                                  tck,
    input  logic                                  trst,
    input  logic                                  tms,
    input  logic                                  tdi,
    output logic                                  tdo,
    output logic                                  tdo_en,
    output tap_ctrl_fsm_t                         tap_state,
    output logic [IR_WIDTH-1:0]                   ir_value,
    input  logic [NUM_USER_DR-1:0][DR_WIDTH-1:0]  user_dr_in,
    output logic [NUM_USER_DR-1:0][DR_WIDTH-1:0]  user_dr_out,
    output logic [NUM_USER_DR-1:0]                user_capture,
    output logic [NUM_USER_DR-1:0]                user_update
);

    localparam logic [IR_WIDTH-1:0] IDCODE_CODE = IR_WIDTH'(IDCODE_OP);

    if (IR_WIDTH < 2) begin : g_chk_ir_width
        $error("jtag_tap_multi_dr: IR_WIDTH must be >= 2");
    end
    if (NUM_USER_DR < 1 || DR_WIDTH < 1) begin : g_chk_user_size
        $error("jtag_tap_multi_dr: NUM_USER_DR and DR_WIDTH must be >= 1");
    end
    if (USER_BASE + NUM_USER_DR - 1 > bypass_op(IR_WIDTH) - 1) begin : g_chk_user_range
        $error("jtag_tap_multi_dr: user opcodes collide with BYPASS or exceed IR range");
    end
    if (IDCODE_OP >= USER_BASE && IDCODE_OP < USER_BASE + NUM_USER_DR) begin : g_chk_idcode
        $error("jtag_tap_multi_dr: IDCODE_OP overlaps a user opcode");
    end

    logic [IR_WIDTH-1:0]     ir_shift;
    logic [IDCODE_WIDTH-1:0] idcode_shift;
    logic                    bypass_shift;
    logic                    sel_idcode;
    logic                    sel_bypass;
    logic [NUM_USER_DR-1:0]  sel_user;
    logic [NUM_USER_DR-1:0]  user_lsb;
    logic                    dr_lsb;

    jtag_tap_fsm_ah u_fsm (
        .tck       (tck),
        .trst      (trst),
        .tms       (tms),
        .tap_state (tap_state)
    );

    // Instruction decode: anything not IDCODE or a user opcode falls through to BYPASS
    always_comb begin
        sel_idcode = (ir_value == IDCODE_CODE);
        for (int unsigned i = 0; i < NUM_USER_DR; i++) begin
            sel_user[i] = (ir_value == IR_WIDTH'(user_op(USER_BASE, i)));
        end
        sel_bypass = ~sel_idcode & ~(|sel_user);
    end

    assign user_capture = sel_user & {NUM_USER_DR{tap_state == CAPTURE_DR}};

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            ir_shift <= '0;
            ir_value <= IDCODE_CODE;
        end else begin
            case (tap_state)
                CAPTURE_IR:       ir_shift <= IR_WIDTH'(2'b01);
                SHIFT_IR:         ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
                UPDATE_IR:        ir_value <= ir_shift;
                TEST_LOGIC_RESET: ir_value <= IDCODE_CODE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            idcode_shift <= '0;
            bypass_shift <= 1'b0;
        end else if (tap_state == CAPTURE_DR) begin
            if (sel_idcode) idcode_shift <= IDCODE_VAL;
            if (sel_bypass) bypass_shift <= 1'b0;
        end else if (tap_state == SHIFT_DR) begin
            if (sel_idcode) idcode_shift <= {tdi, idcode_shift[IDCODE_WIDTH-1:1]};
            if (sel_bypass) bypass_shift <= tdi;
        end
    end

    // Per-register shift/update stage; outputs only change on this register's own Update-DR
    for (genvar g = 0; g < NUM_USER_DR; g++) begin : g_user
        logic [DR_WIDTH-1:0] shift_q;
        logic [DR_WIDTH-1:0] out_q;
        logic                upd_q;

        always_ff @(posedge tck or posedge trst) begin
            if (trst) begin
                shift_q <= '0;
                out_q   <= '0;
                upd_q   <= 1'b0;
            end else begin
                upd_q <= (tap_state == UPDATE_DR) && sel_user[g];
                if (sel_user[g]) begin
                    case (tap_state)
                        CAPTURE_DR: shift_q <= user_dr_in[g];
                        SHIFT_DR:   shift_q <= (shift_q >> 1) | (DR_WIDTH'(tdi) << (DR_WIDTH - 1));
                        UPDATE_DR:  out_q   <= shift_q;
                        default: ;
                    endcase
                end
            end
        end

        assign user_dr_out[g] = out_q;
        assign user_update[g] = upd_q;
        assign user_lsb[g]    = shift_q[0];
    end

    always_comb begin
        dr_lsb = bypass_shift;
        if (sel_idcode)     dr_lsb = idcode_shift[0];
        else if (|sel_user) dr_lsb = |(sel_user & user_lsb);
    end

    // Falling-edge output stage so tdo is stable around the next rising edge
    always_ff @(negedge tck or posedge trst) begin
        if (trst) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            case (tap_state)
                SHIFT_IR: begin
                    tdo    <= ir_shift[0];
                    tdo_en <= 1'b1;
                end
                SHIFT_DR: begin
                    tdo    <= dr_lsb;
                    tdo_en <= 1'b1;
                end
                default: begin
                    tdo    <= 1'b0;
                    tdo_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_tap_multi_dr.sv
// Scoreboard bench for jtag_tap_multi_dr: expected tdo bits are queued as stimulus is built.
module tb_jtag_tap_multi_dr;
    import jtag_pkg::*;

    logic                 tck  = 1'b0;
    logic                 trst = 1'b1;
    logic                 tms  = 1'b1;
    logic                 tdi  = 1'b0;
    logic                 tdo;
    logic                 tdo_en;
    tap_ctrl_fsm_t        tap_state;
    logic [3:0]           ir_value;
    logic [2:0][31:0]     user_dr_in = '0;
    logic [2:0][31:0]     user_dr_out;
    logic [2:0]           user_capture;
    logic [2:0]           user_update;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        exp_q[$];
    logic        samp_tdo;
    logic        samp_en;
    logic [63:0] dout;
    int          en_cnt;

    jtag_tap_multi_dr dut (
        .tck          (tck),
        .trst         (trst),
        .tms          (tms),
        .tdi          (tdi),
        .tdo          (tdo),
        .tdo_en       (tdo_en),
        .tap_state    (tap_state),
        .ir_value     (ir_value),
        .user_dr_in   (user_dr_in),
        .user_dr_out  (user_dr_out),
        .user_capture (user_capture),
        .user_update  (user_update)
    );

    always #5 tck = ~tck;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // One tck cycle: sample tdo/tdo_en after the falling edge, drive inputs, wait past rising edge
    task automatic step(input logic tms_v, input logic tdi_v);
        @(negedge tck);
        #1;
        samp_tdo = tdo;
        samp_en  = tdo_en;
        tms      = tms_v;
        tdi      = tdi_v;
        @(posedge tck);
        #1;
    endtask

    task automatic shift_bits(input int n, input logic [63:0] din, input logic last_exit);
        dout   = '0;
        en_cnt = 0;
        for (int k = 0; k < n; k++) begin
            step(last_exit && (k == n - 1), din[k]);
            dout[k] = samp_tdo;
            if (samp_en) en_cnt++;
        end
    endtask

    // RTI -> load IR -> RTI; tdo bits of the IR shift land in dout
    task automatic shift_ir(input logic [3:0] val);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        shift_bits(4, 64'(val), 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic goto_shift_dr();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic finish_dr();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (tap_state !== TEST_LOGIC_RESET) begin n_bad++; $display("FAIL reset_state: got %0h want %0h", tap_state, TEST_LOGIC_RESET); end
        n_cmp++; if (ir_value !== 4'h1) begin n_bad++; $display("FAIL reset_ir: got %0h want 1", ir_value); end
        n_cmp++; if (tdo !== 1'b0 || tdo_en !== 1'b0) begin n_bad++; $display("FAIL reset_tdo: got %b/%b want 0/0", tdo, tdo_en); end
        n_cmp++; if (user_dr_out !== '0 || user_update !== 3'b000) begin n_bad++; $display("FAIL reset_user: got %h/%b want 0/000", user_dr_out, user_update); end
        @(negedge tck);
        trst = 1'b0;
        step(1'b0, 1'b0);
        n_cmp++; if (tap_state !== RUN_TEST_IDLE) begin n_bad++; $display("FAIL reset_to_rti: got %0h want %0h", tap_state, RUN_TEST_IDLE); end
    endtask

    task automatic test_idcode();
        logic [31:0] pat;
        pat = 32'h0000010F;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n_cmp++; if (user_capture !== 3'b000) begin n_bad++; $display("FAIL idcode_capture: got %b want 000", user_capture); end
        step(1'b0, 1'b0);
        n_cmp++; if (samp_en !== 1'b0) begin n_bad++; $display("FAIL idcode_en_before: got %b want 0", samp_en); end
        for (int k = 0; k < 32; k++) exp_q.push_back(pat[k]);
        shift_bits(32, 64'h0000_0000_A5A5_0F0F, 1'b1);
        for (int k = 0; k < 32; k++) begin
            logic e;
            e = exp_q.pop_front();
            n_cmp++; if (dout[k] !== e) begin n_bad++; $display("FAIL idcode_tdo bit %0d: got %b want %b", k, dout[k], e); end
        end
        n_cmp++; if (en_cnt != 32) begin n_bad++; $display("FAIL idcode_en_count: got %0d want 32", en_cnt); end
        finish_dr();
        n_cmp++; if (samp_en !== 1'b0) begin n_bad++; $display("FAIL idcode_en_after: got %b want 0", samp_en); end
        n_cmp++; if (user_dr_out !== '0) begin n_bad++; $display("FAIL idcode_no_update: got %h want 0", user_dr_out); end
    endtask

    task automatic test_user_dr();
        logic [31:0] pat;
        pat = 32'hDEADBEEF;
        user_dr_in[0] = 32'h11111111;
        user_dr_in[1] = pat;
        user_dr_in[2] = 32'h22222222;
        shift_ir(4'h5);
        n_cmp++; if (ir_value !== 4'h5) begin n_bad++; $display("FAIL user_ir: got %0h want 5", ir_value); end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n_cmp++; if (tap_state !== CAPTURE_DR || user_capture !== 3'b010) begin n_bad++; $display("FAIL user_capture: got %0h/%b want %0h/010", tap_state, user_capture, CAPTURE_DR); end
        step(1'b0, 1'b0);
        for (int k = 0; k < 32; k++) exp_q.push_back(pat[k]);
        shift_bits(32, 64'h12345678, 1'b1);
        for (int k = 0; k < 32; k++) begin
            logic e;
            e = exp_q.pop_front();
            n_cmp++; if (dout[k] !== e) begin n_bad++; $display("FAIL user_tdo bit %0d: got %b want %b", k, dout[k], e); end
        end
        step(1'b1, 1'b0);
        n_cmp++; if (user_update !== 3'b000) begin n_bad++; $display("FAIL user_update_early: got %b want 000", user_update); end
        step(1'b0, 1'b0);
        n_cmp++; if (user_dr_out[1] !== 32'h12345678) begin n_bad++; $display("FAIL user_dr1: got %h want 12345678", user_dr_out[1]); end
        n_cmp++; if (user_update !== 3'b010) begin n_bad++; $display("FAIL user_update_pulse: got %b want 010", user_update); end
        n_cmp++; if (user_dr_out[0] !== 32'h0 || user_dr_out[2] !== 32'h0) begin n_bad++; $display("FAIL user_others: got %h/%h want 0/0", user_dr_out[0], user_dr_out[2]); end
        step(1'b0, 1'b0);
        n_cmp++; if (user_update !== 3'b000) begin n_bad++; $display("FAIL user_update_width: got %b want 000", user_update); end
    endtask

    task automatic test_tlr_from_shift();
        logic [2:0][31:0] saved;
        saved = user_dr_out;
        shift_ir(4'h1);
        goto_shift_dr();
        shift_bits(4, 64'hF, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0);
            n_cmp++; if (user_update !== 3'b000) begin n_bad++; $display("FAIL tlr_update step %0d: got %b want 000", k, user_update); end
        end
        n_cmp++; if (tap_state !== TEST_LOGIC_RESET) begin n_bad++; $display("FAIL tlr_state: got %0h want %0h", tap_state, TEST_LOGIC_RESET); end
        n_cmp++; if (ir_value !== 4'h1) begin n_bad++; $display("FAIL tlr_ir: got %0h want 1", ir_value); end
        n_cmp++; if (user_dr_out !== saved) begin n_bad++; $display("FAIL tlr_user_hold: got %h want %h", user_dr_out, saved); end
        step(1'b0, 1'b0);
    endtask

    task automatic test_bypass();
        logic [7:0] pat;
        pat = 8'hA5;
        shift_ir(4'hF);
        goto_shift_dr();
        exp_q.push_back(1'b0);
        for (int k = 0; k < 7; k++) exp_q.push_back(pat[k]);
        shift_bits(8, 64'(pat), 1'b1);
        for (int k = 0; k < 8; k++) begin
            logic e;
            e = exp_q.pop_front();
            n_cmp++; if (dout[k] !== e) begin n_bad++; $display("FAIL bypass_tdo bit %0d: got %b want %b", k, dout[k], e); end
        end
        finish_dr();
        n_cmp++; if (user_dr_out[1] !== 32'h12345678 || user_update !== 3'b000) begin n_bad++; $display("FAIL bypass_no_update: got %h/%b", user_dr_out[1], user_update); end
    endtask

    task automatic test_ir_capture();
        logic [3:0] cap;
        logic [7:0] pat;
        cap = 4'b0001;
        pat = 8'h3C;
        for (int k = 0; k < 4; k++) exp_q.push_back(cap[k]);
        shift_ir(4'h9);
        for (int k = 0; k < 4; k++) begin
            logic e;
            e = exp_q.pop_front();
            n_cmp++; if (dout[k] !== e) begin n_bad++; $display("FAIL ircap_tdo bit %0d: got %b want %b", k, dout[k], e); end
        end
        n_cmp++; if (ir_value !== 4'h9) begin n_bad++; $display("FAIL ircap_ir: got %0h want 9", ir_value); end
        goto_shift_dr();
        exp_q.push_back(1'b0);
        for (int k = 0; k < 7; k++) exp_q.push_back(pat[k]);
        shift_bits(8, 64'(pat), 1'b1);
        for (int k = 0; k < 8; k++) begin
            logic e;
            e = exp_q.pop_front();
            n_cmp++; if (dout[k] !== e) begin n_bad++; $display("FAIL unmapped_tdo bit %0d: got %b want %b", k, dout[k], e); end
        end
        finish_dr();
    endtask

    task automatic test_back_to_back();
        logic [31:0] pat;
        logic [31:0] din;
        logic [31:0] got;
        pat = 32'h55AA55AA;
        din = 32'h0BADF00D;
        user_dr_in[2] = 32'hCAFEF00D;
        shift_ir(4'h6);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        n_cmp++; if (user_dr_out[2] !== 32'hCAFEF00D) begin n_bad++; $display("FAIL zero_len_wb: got %h want cafef00d", user_dr_out[2]); end
        n_cmp++; if (user_update !== 3'b100 || tap_state !== SELECT_DR) begin n_bad++; $display("FAIL b2b_pulse1: got %b/%0h want 100/%0h", user_update, tap_state, SELECT_DR); end
        user_dr_in[2] = pat;
        step(1'b0, 1'b0);
        n_cmp++; if (user_update !== 3'b000) begin n_bad++; $display("FAIL b2b_pulse1_end: got %b want 000", user_update); end
        step(1'b0, 1'b0);
        for (int k = 0; k < 32; k++) exp_q.push_back(pat[k]);
        shift_bits(16, 64'(din[15:0]), 1'b1);
        got[15:0] = dout[15:0];
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        n_cmp++; if (samp_en !== 1'b0 || tap_state !== PAUSE_DR) begin n_bad++; $display("FAIL pause_en: got %b/%0h want 0/%0h", samp_en, tap_state, PAUSE_DR); end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        shift_bits(16, 64'(din[31:16]), 1'b1);
        got[31:16] = dout[15:0];
        for (int k = 0; k < 32; k++) begin
            logic e;
            e = exp_q.pop_front();
            n_cmp++; if (got[k] !== e) begin n_bad++; $display("FAIL b2b_tdo bit %0d: got %b want %b", k, got[k], e); end
        end
        finish_dr();
        n_cmp++; if (user_dr_out[2] !== din || user_update !== 3'b100) begin n_bad++; $display("FAIL b2b_dr2: got %h/%b want %h/100", user_dr_out[2], user_update, din); end
        n_cmp++; if (user_dr_out[1] !== 32'h12345678) begin n_bad++; $display("FAIL b2b_dr1_hold: got %h want 12345678", user_dr_out[1]); end
    endtask

    task automatic test_trst_abort();
        user_dr_in[0] = 32'hA5A5A5A5;
        shift_ir(4'h4);
        goto_shift_dr();
        shift_bits(5, 64'h1F, 1'b0);
        #2;
        trst = 1'b1;
        #1;
        n_cmp++; if (tap_state !== TEST_LOGIC_RESET) begin n_bad++; $display("FAIL trst_state: got %0h want %0h", tap_state, TEST_LOGIC_RESET); end
        n_cmp++; if (user_dr_out !== '0) begin n_bad++; $display("FAIL trst_user_clear: got %h want 0", user_dr_out); end
        n_cmp++; if (tdo_en !== 1'b0 || tdo !== 1'b0) begin n_bad++; $display("FAIL trst_tdo: got %b/%b want 0/0", tdo, tdo_en); end
        n_cmp++; if (ir_value !== 4'h1) begin n_bad++; $display("FAIL trst_ir: got %0h want 1", ir_value); end
        @(negedge tck);
        #1;
        trst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0);
            n_cmp++; if (user_update !== 3'b000 || user_dr_out !== '0) begin n_bad++; $display("FAIL trst_no_update step %0d: got %b/%h want 000/0", k, user_update, user_dr_out); end
        end
        step(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_idcode();
        test_user_dr();
        test_tlr_from_shift();
        test_bypass();
        test_ir_capture();
        test_back_to_back();
        test_trst_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
